// File: rtl/dot_product_scheduler.sv
// Credit-limited column scheduler for a pipelined dot-product tree: issues J-column reads,
// tags tree results with their column index, buffers them in a FIFO and accumulates popped results.
module dot_product_scheduler #(
   parameter int MAX_COLS   = 256,
   parameter int RES_W      = 13,
   parameter int FIFO_DEPTH = 4,
   parameter int COL_W      = $clog2(MAX_COLS + 1),
   parameter int ACC_W      = RES_W + $clog2(MAX_COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             job_start_i,
   input  logic [COL_W-1:0] num_cols_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             mem_rd_en_o,
   output logic [COL_W-1:0] mem_addr_o,
   input  logic             mem_rvalid_i,
   output logic             tree_start_o,
   input  logic             tree_start_i,
   input  logic [RES_W-1:0] tree_dot_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [RES_W-1:0] res_data_o,
   output logic [COL_W-1:0] res_idx_o,
   output logic [ACC_W-1:0] acc_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [COL_W-1:0] DEPTH_C = COL_W'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   FULL_C  = (PTR_W + 1)'(FIFO_DEPTH);

   logic [1:0]       r_state;
   logic [COL_W-1:0] r_num_cols;
   logic [COL_W-1:0] r_issue_cnt;
   logic [COL_W-1:0] r_ret_cnt;
   logic [COL_W-1:0] r_pop_cnt;
   logic [ACC_W-1:0] r_acc;
   logic [RES_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic [COL_W-1:0] r_fifo_idx  [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic [1:0]       w_state_nxt;
   logic             w_active;
   logic             w_start;
   logic [COL_W-1:0] w_outstanding;
   logic             w_rd_en;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push_req;
   logic             w_push;
   logic             w_cnt_pop;
   logic [COL_W-1:0] w_pop_cnt_nxt;
   logic [ACC_W-1:0] w_head_ext;

   assign w_active      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign w_start       = (r_state == S_IDLE) && job_start_i;
   // In-flight reads count against the credit, so the tree can never overrun the FIFO.
   assign w_outstanding = r_issue_cnt - r_pop_cnt;
   assign w_rd_en       = (r_state == S_ISSUE) && (w_outstanding < DEPTH_C) && (r_issue_cnt < r_num_cols);
   assign w_full        = (r_count == FULL_C);
   assign w_empty       = (r_count == {(PTR_W + 1){1'b0}});
   assign w_pop         = !w_empty && res_ready_i;
   assign w_push_req    = tree_start_i && w_active;
   assign w_push        = w_push_req && (!w_full || w_pop);
   assign w_cnt_pop     = w_pop && w_active;
   assign w_pop_cnt_nxt = r_pop_cnt + {{(COL_W - 1){1'b0}}, w_cnt_pop};
   assign w_head_ext    = {{(ACC_W - RES_W){r_fifo_data[r_rd_ptr][RES_W-1]}}, r_fifo_data[r_rd_ptr]};

   // Job sequencing; DONE is entered on the edge of the final pop so done_o follows it by one cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (job_start_i) begin
               w_state_nxt = (num_cols_i != {COL_W{1'b0}}) ? S_ISSUE : S_DONE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (r_issue_cnt == r_num_cols) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_DRAIN: begin
            if (w_pop_cnt_nxt == r_num_cols) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, job counters and the running sum of popped results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_num_cols  <= {COL_W{1'b0}};
         r_issue_cnt <= {COL_W{1'b0}};
         r_ret_cnt   <= {COL_W{1'b0}};
         r_pop_cnt   <= {COL_W{1'b0}};
         r_acc       <= {ACC_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_num_cols  <= num_cols_i;
            r_issue_cnt <= {COL_W{1'b0}};
            r_ret_cnt   <= {COL_W{1'b0}};
            r_pop_cnt   <= {COL_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
         end else begin
            if (w_rd_en) begin
               r_issue_cnt <= r_issue_cnt + COL_W'(1'b1);
            end
            if (w_push_req) begin
               r_ret_cnt <= r_ret_cnt + COL_W'(1'b1);
            end
            if (w_cnt_pop) begin
               r_pop_cnt <= w_pop_cnt_nxt;
               r_acc     <= r_acc + w_head_ext;
            end
         end
      end
   end

   // Result FIFO; a push into a full FIFO is only honoured when a pop frees the slot that same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_fifo_data[i] <= {RES_W{1'b0}};
            r_fifo_idx[i]  <= {COL_W{1'b0}};
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {(PTR_W + 1){1'b0}};
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= tree_dot_i;
            r_fifo_idx[r_wr_ptr]  <= r_ret_cnt;
            r_wr_ptr              <= r_wr_ptr + PTR_W'(1'b1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1'b1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1'b1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign busy_o       = (r_state != S_IDLE);
   assign done_o       = (r_state == S_DONE);
   assign mem_rd_en_o  = w_rd_en;
   assign mem_addr_o   = r_issue_cnt;
   assign tree_start_o = mem_rvalid_i && busy_o;
   assign res_valid_o  = !w_empty;
   assign res_data_o   = r_fifo_data[r_rd_ptr];
   assign res_idx_o    = r_fifo_idx[r_rd_ptr];
   assign acc_o        = r_acc;

   dot_product_scheduler_chk u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .idle_i       (r_state == S_IDLE),
      .push_req_i   (w_push_req),
      .full_i       (w_full),
      .pop_i        (w_pop),
      .mem_rvalid_i (mem_rvalid_i)
   );

endmodule

// Protocol checks: the credit scheme must never overrun the FIFO, and memory must stay quiet while idle.
module dot_product_scheduler_chk (
   input logic clk,
   input logic rst_n,
   input logic idle_i,
   input logic push_req_i,
   input logic full_i,
   input logic pop_i,
   input logic mem_rvalid_i
);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_req_i && full_i && !pop_i));
   a_no_idle_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(idle_i && mem_rvalid_i));

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Self-checking bench for dot_product_scheduler: models the J-memory and the tree with
// configurable latencies and checks issued reads, popped results and the running sum.
module tb_dot_product_scheduler;

   localparam int COL_W = 9;
   localparam int RES_W = 13;
   localparam int ACC_W = 21;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             job_start_i;
   logic [COL_W-1:0] num_cols_i;
   logic             busy_o, done_o, mem_rd_en_o, tree_start_o, res_valid_o;
   logic [COL_W-1:0] mem_addr_o, res_idx_o;
   logic             mem_rvalid_i, tree_start_i, res_ready_i;
   logic [RES_W-1:0] tree_dot_i, res_data_o;
   logic [ACC_W-1:0] acc_o;

   dot_product_scheduler dut (
      .clk(clk), .rst_n(rst_n), .job_start_i(job_start_i), .num_cols_i(num_cols_i),
      .busy_o(busy_o), .done_o(done_o), .mem_rd_en_o(mem_rd_en_o), .mem_addr_o(mem_addr_o),
      .mem_rvalid_i(mem_rvalid_i), .tree_start_o(tree_start_o), .tree_start_i(tree_start_i),
      .tree_dot_i(tree_dot_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_data_o(res_data_o), .res_idx_o(res_idx_o), .acc_o(acc_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Environment: J-memory with latency 1 or 2, tree combinational or 3 deep, optional injected strobe.
   int                      mem_lat = 1;
   int                      tree_lat = 0;
   logic                    inject = 1'b0;
   logic [RES_W-1:0]        inj_data = 13'd0;
   logic signed [RES_W-1:0] col_val [0:255];
   logic                    mv [0:1];
   logic [COL_W-1:0]        ma [0:1];
   logic                    tv [0:2];
   logic [RES_W-1:0]        td [0:2];
   logic [COL_W-1:0]        w_raddr;
   logic [RES_W-1:0]        w_rdata, m_td;
   logic                    m_ts;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv[0] <= 1'b0; mv[1] <= 1'b0; ma[0] <= 9'd0; ma[1] <= 9'd0;
         tv[0] <= 1'b0; tv[1] <= 1'b0; tv[2] <= 1'b0;
         td[0] <= 13'd0; td[1] <= 13'd0; td[2] <= 13'd0;
      end else begin
         mv[0] <= mem_rd_en_o; mv[1] <= mv[0];
         ma[0] <= mem_addr_o;  ma[1] <= ma[0];
         tv[0] <= tree_start_o; tv[1] <= tv[0]; tv[2] <= tv[1];
         td[0] <= w_rdata;      td[1] <= td[0]; td[2] <= td[1];
      end
   end

   always_comb begin
      mem_rvalid_i = (mem_lat == 2) ? mv[1] : mv[0];
      w_raddr      = (mem_lat == 2) ? ma[1] : ma[0];
      w_rdata      = col_val[w_raddr[7:0]];
      if (tree_lat == 0) begin
         m_ts = tree_start_o;
         m_td = w_rdata;
      end else begin
         m_ts = tv[2];
         m_td = td[2];
      end
      tree_start_i = m_ts | inject;
      tree_dot_i   = inject ? inj_data : m_td;
   end

   // Event log: reads (with outstanding count at issue), pops and done pulses.
   int                     rd_q[$], rdc_q[$], occ_q[$], popc_q[$], donec_q[$];
   logic [COL_W+RES_W-1:0] pop_q[$];

   always @(posedge clk) begin
      if (rst_n) begin
         if (mem_rd_en_o) begin
            occ_q.push_back(rd_q.size() - pop_q.size());
            rd_q.push_back(int'(mem_addr_o));
            rdc_q.push_back(cyc);
         end
         if (res_valid_o && res_ready_i) begin
            pop_q.push_back({res_idx_o, res_data_o});
            popc_q.push_back(cyc);
         end
         if (done_o) donec_q.push_back(cyc);
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_q.delete(); rdc_q.delete(); occ_q.delete(); popc_q.delete(); donec_q.delete(); pop_q.delete();
   endtask

   task automatic fill_cols(input bit constant15);
      for (int i = 0; i < 256; i++) begin
         col_val[i] = constant15 ? 13'sd15 : RES_W'($urandom_range(0, 8191));
      end
   endtask

   task automatic start_job(input int n, output int s);
      job_start_i = 1'b1;
      num_cols_i  = COL_W'(n);
      s           = cyc;
      tick();
      job_start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rand_ready, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         res_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         if (done_o) begin
            tick();
            ok = 1'b1;
            break;
         end
      end
   endtask

   function automatic int max_occ();
      int m = 0;
      foreach (occ_q[i]) if (occ_q[i] > m) m = occ_q[i];
      return m;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; job_start_i = 1'b0; num_cols_i = 9'd0; res_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy_o, done_o, mem_rd_en_o, tree_start_o, res_valid_o} !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b, want 00000", {busy_o, done_o, mem_rd_en_o, tree_start_o, res_valid_o});
      end
      n_cmp++;
      if ({mem_addr_o, res_idx_o, res_data_o, acc_o} !== 52'd0) begin
         n_bad++;
         $display("FAIL reset_data: got addr %0d idx %0d data %0d acc %0d, want all 0", mem_addr_o, res_idx_o, res_data_o, acc_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   // 8 columns, latency 1, combinational tree, consumer always ready.
   task automatic test_single_job();
      int s, sum;
      bit ok;
      mem_lat = 1; tree_lat = 0; fill_cols(1'b0); clear_logs(); res_ready_i = 1'b1;
      start_job(8, s);
      wait_done(200, 1'b0, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL t1_done_timeout: got no done_o, want done_o"); end
      n_cmp++;
      if (rd_q.size() != 8 || pop_q.size() != 8) begin
         n_bad++; $display("FAIL t1_counts: got %0d reads %0d pops, want 8 and 8", rd_q.size(), pop_q.size());
      end else begin
         sum = 0;
         for (int i = 0; i < 8; i++) begin
            sum += int'(col_val[i]);
            n_cmp++;
            if (rd_q[i] != i) begin n_bad++; $display("FAIL t1_addr[%0d]: got %0d, want %0d", i, rd_q[i], i); end
            n_cmp++;
            if (pop_q[i] !== {COL_W'(i), col_val[i]}) begin
               n_bad++;
               $display("FAIL t1_pop[%0d]: got idx %0d data %0d, want idx %0d data %0d", i, pop_q[i][21:13], $signed(pop_q[i][12:0]), i, col_val[i]);
            end
         end
         n_cmp++;
         if (rdc_q[7] - rdc_q[0] != 7) begin n_bad++; $display("FAIL t1_rd_b2b: got span %0d, want 7", rdc_q[7] - rdc_q[0]); end
         n_cmp++;
         if (popc_q[7] - popc_q[0] != 7) begin n_bad++; $display("FAIL t1_pop_b2b: got span %0d, want 7", popc_q[7] - popc_q[0]); end
         n_cmp++;
         if (donec_q.size() != 1 || donec_q[0] != popc_q[7] + 1) begin
            n_bad++; $display("FAIL t1_done_timing: got %0d pulses, want 1 at cycle %0d", donec_q.size(), popc_q[7] + 1);
         end
         n_cmp++;
         if (acc_o !== ACC_W'(sum)) begin n_bad++; $display("FAIL t1_acc: got %0d, want %0d", $signed(acc_o), sum); end
      end
   endtask

   // Zero-column job: straight to DONE, no reads, busy only during DONE.
   task automatic test_zero_cols();
      int s;
      clear_logs(); res_ready_i = 1'b1;
      n_cmp++;
      if (busy_o !== 1'b0) begin n_bad++; $display("FAIL t2_idle_busy: got %b, want 0", busy_o); end
      start_job(0, s);
      n_cmp++;
      if ({busy_o, done_o} !== 2'b11) begin n_bad++; $display("FAIL t2_done_state: got %b, want 11", {busy_o, done_o}); end
      n_cmp++;
      if (acc_o !== 21'd0) begin n_bad++; $display("FAIL t2_acc_clear: got %0d, want 0", $signed(acc_o)); end
      tick();
      n_cmp++;
      if ({busy_o, done_o} !== 2'b00) begin n_bad++; $display("FAIL t2_back_idle: got %b, want 00", {busy_o, done_o}); end
      n_cmp++;
      if (rd_q.size() != 0 || donec_q.size() != 1 || (donec_q.size() == 1 && donec_q[0] != s + 1)) begin
         n_bad++; $display("FAIL t2_events: got %0d reads %0d dones, want 0 reads, 1 done at %0d", rd_q.size(), donec_q.size(), s + 1);
      end
   endtask

   // Consumer stalled: exactly FIFO_DEPTH reads, then one more read per freed credit.
   task automatic test_credit_stall();
      int s, sum;
      bit ok;
      mem_lat = 1; tree_lat = 0; fill_cols(1'b0); clear_logs(); res_ready_i = 1'b0;
      start_job(12, s);
      repeat (20) tick();
      n_cmp++;
      if (rd_q.size() != 4) begin n_bad++; $display("FAIL t3_stall_reads: got %0d, want 4", rd_q.size()); end
      n_cmp++;
      if ({busy_o, res_valid_o, mem_rd_en_o} !== 3'b110) begin
         n_bad++; $display("FAIL t3_stall_state: got %b, want 110", {busy_o, res_valid_o, mem_rd_en_o});
      end
      wait_done(300, 1'b0, ok);
      n_cmp++;
      if (!ok || rd_q.size() != 12 || pop_q.size() != 12) begin
         n_bad++; $display("FAIL t3_counts: got done %b, %0d reads %0d pops, want 1, 12, 12", ok, rd_q.size(), pop_q.size());
      end else begin
         sum = 0;
         for (int i = 0; i < 12; i++) begin
            sum += int'(col_val[i]);
            n_cmp++;
            if (rd_q[i] != i || pop_q[i] !== {COL_W'(i), col_val[i]}) begin
               n_bad++;
               $display("FAIL t3_entry[%0d]: got addr %0d idx %0d data %0d, want %0d/%0d/%0d", i, rd_q[i], pop_q[i][21:13], $signed(pop_q[i][12:0]), i, i, col_val[i]);
            end
         end
         n_cmp++;
         if (acc_o !== ACC_W'(sum)) begin n_bad++; $display("FAIL t3_acc: got %0d, want %0d", $signed(acc_o), sum); end
      end
      n_cmp++;
      if (max_occ() >= 4) begin n_bad++; $display("FAIL t3_credit: got outstanding %0d at issue, want < 4", max_occ()); end
   endtask

   // Push and pop on the same edge while full (extra injected strobe) keeps order and loses nothing.
   task automatic test_full_push_pop();
      int s;
      logic [RES_W-1:0] exp_d;
      mem_lat = 1; tree_lat = 0; fill_cols(1'b0); clear_logs(); res_ready_i = 1'b0;
      start_job(6, s);
      repeat (10) tick();
      n_cmp++;
      if (rd_q.size() != 4 || res_idx_o !== 9'd0) begin
         n_bad++; $display("FAIL t4_precond: got %0d reads head %0d, want 4 reads head 0", rd_q.size(), res_idx_o);
      end
      inj_data = RES_W'($urandom_range(0, 8191));
      inject = 1'b1; res_ready_i = 1'b1;
      tick();
      inject = 1'b0; res_ready_i = 1'b0;
      n_cmp++;
      if (res_valid_o !== 1'b1 || res_idx_o !== 9'd1 || res_data_o !== col_val[1]) begin
         n_bad++; $display("FAIL t4_head_after: got valid %b idx %0d data %0d, want 1/1/%0d", res_valid_o, res_idx_o, $signed(res_data_o), col_val[1]);
      end
      tick();
      res_ready_i = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (pop_q.size() >= 7 && !res_valid_o) break;
         tick();
      end
      repeat (3) tick();
      n_cmp++;
      if (pop_q.size() != 7) begin
         n_bad++; $display("FAIL t4_pop_count: got %0d, want 7", pop_q.size());
      end else begin
         for (int i = 0; i < 7; i++) begin
            exp_d = (i < 4) ? col_val[i] : ((i == 4) ? inj_data : col_val[i - 1]);
            n_cmp++;
            if (pop_q[i] !== {COL_W'(i), exp_d}) begin
               n_bad++; $display("FAIL t4_pop[%0d]: got idx %0d data %0d, want idx %0d data %0d", i, pop_q[i][21:13], $signed(pop_q[i][12:0]), i, $signed(exp_d));
            end
         end
      end
      n_cmp++;
      if ({busy_o, res_valid_o} !== 2'b00 || donec_q.size() != 1) begin
         n_bad++; $display("FAIL t4_end: got busy/valid %b and %0d dones, want 00 and 1", {busy_o, res_valid_o}, donec_q.size());
      end
   endtask

   // Start during ISSUE is ignored; reset during DRAIN clears everything; a fresh job then runs.
   task automatic test_start_ignore_and_reset();
      int s, sum;
      bit ok;
      mem_lat = 1; tree_lat = 0; fill_cols(1'b0); clear_logs(); res_ready_i = 1'b1;
      start_job(20, s);
      repeat (3) tick();
      job_start_i = 1'b1; num_cols_i = 9'd3;
      tick();
      job_start_i = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (rd_q.size() >= 20) break;
         tick();
      end
      res_ready_i = 1'b0;
      tick();
      n_cmp++;
      if ({busy_o, mem_rd_en_o, res_valid_o, done_o} !== 4'b1010) begin
         n_bad++; $display("FAIL t5_drain_state: got %b, want 1010", {busy_o, mem_rd_en_o, res_valid_o, done_o});
      end
      n_cmp++;
      if (rd_q.size() != 20) begin
         n_bad++; $display("FAIL t5_reads: got %0d, want 20", rd_q.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (rd_q[i] != i) begin n_bad++; $display("FAIL t5_addr[%0d]: got %0d, want %0d", i, rd_q[i], i); end
         end
      end
      foreach (pop_q[i]) begin
         n_cmp++;
         if (pop_q[i] !== {COL_W'(i), col_val[i]}) begin
            n_bad++; $display("FAIL t5_pop[%0d]: got idx %0d, want %0d", i, pop_q[i][21:13], i);
         end
      end
      rst_n = 1'b0;
      tick();
      n_cmp++;
      if ({busy_o, done_o, mem_rd_en_o, tree_start_o, res_valid_o, mem_addr_o, res_idx_o, res_data_o, acc_o} !== 57'd0) begin
         n_bad++; $display("FAIL t5_reset_outputs: got busy %b valid %b idx %0d acc %0d, want all 0", busy_o, res_valid_o, res_idx_o, acc_o);
      end
      rst_n = 1'b1;
      tick();
      fill_cols(1'b0); clear_logs(); res_ready_i = 1'b1;
      start_job(5, s);
      wait_done(200, 1'b0, ok);
      n_cmp++;
      if (!ok || pop_q.size() != 5) begin
         n_bad++; $display("FAIL t5_new_job: got done %b pops %0d, want 1 and 5", ok, pop_q.size());
      end else begin
         sum = 0;
         for (int i = 0; i < 5; i++) begin
            sum += int'(col_val[i]);
            n_cmp++;
            if (pop_q[i] !== {COL_W'(i), col_val[i]}) begin
               n_bad++; $display("FAIL t5_new_pop[%0d]: got idx %0d data %0d, want %0d/%0d", i, pop_q[i][21:13], $signed(pop_q[i][12:0]), i, col_val[i]);
            end
         end
         n_cmp++;
         if (acc_o !== ACC_W'(sum)) begin n_bad++; $display("FAIL t5_acc: got %0d, want %0d", $signed(acc_o), sum); end
      end
   endtask

   // Full-size job, mem latency 2, tree latency 3, random consumer ready, every result +15.
   task automatic test_long_random();
      int s;
      bit ok;
      mem_lat = 2; tree_lat = 3; fill_cols(1'b1); clear_logs();
      res_ready_i = 1'($urandom_range(0, 1));
      start_job(256, s);
      wait_done(8000, 1'b1, ok);
      n_cmp++;
      if (!ok || rd_q.size() != 256 || pop_q.size() != 256) begin
         n_bad++; $display("FAIL t6_counts: got done %b, %0d reads %0d pops, want 1, 256, 256", ok, rd_q.size(), pop_q.size());
      end else begin
         for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (pop_q[i] !== {COL_W'(i), 13'sd15}) begin
               n_bad++; $display("FAIL t6_pop[%0d]: got idx %0d data %0d, want idx %0d data 15", i, pop_q[i][21:13], $signed(pop_q[i][12:0]), i);
            end
         end
         n_cmp++;
         if (donec_q.size() != 1 || donec_q[0] != popc_q[255] + 1) begin
            n_bad++; $display("FAIL t6_done_timing: got %0d pulses, want 1 at cycle %0d", donec_q.size(), popc_q[255] + 1);
         end
      end
      n_cmp++;
      if (acc_o !== 21'd3840) begin n_bad++; $display("FAIL t6_acc: got %0d, want 3840", $signed(acc_o)); end
      n_cmp++;
      if (max_occ() >= 4) begin n_bad++; $display("FAIL t6_credit: got outstanding %0d at issue, want < 4", max_occ()); end
   endtask

   initial begin
      test_reset();
      test_single_job();
      test_zero_cols();
      test_credit_stall();
      test_full_push_pop();
      test_start_ignore_and_reset();
      test_long_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
